// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and FSM encoding for the fetch queue unit.
package fetch_queue_unit_pkg;

  localparam int          FQ_WORD_SIZE = 32;
  localparam int          FQ_ADDR_W    = 32;
  localparam int          FQ_DEPTH     = 4;
  localparam int          FQ_PC_STEP   = 4;
  localparam logic [31:0] FQ_RESET_PC  = 32'h0000_0000;

  typedef enum logic [0:0] {
    FQ_FETCH = 1'b0,
    FQ_FLUSH = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_unit_chk.sv
// Protocol checker for the fetch queue unit (simulation assertions only).
module fetch_queue_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic mem_rvalid,
  input logic tag_empty,
  input logic tag_push,
  input logic tag_full,
  input logic q_push,
  input logic q_full
);

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid |-> !tag_empty);
  a_tag_no_overflow:    assert property (@(posedge clk) disable iff (!rst_n) tag_push |-> !tag_full);
  a_q_no_overflow:      assert property (@(posedge clk) disable iff (!rst_n) q_push |-> !q_full);

endmodule

// File: rtl/fq_sync_fifo.sv
// Synchronous FIFO with clear; reused for the data queue and the per-request PC tags.
module fq_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;

  // storage is reset so the head reads zero straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !clr) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
    end
  end

  // pointer update; clear dominates push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
    end
  end

  assign count = wr_ptr_r - rd_ptr_r;
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem_r[rd_ptr_r[PTR_W-1:0]];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with prefetch queue and redirect flush.
// Optional alignment check on redirect targets: define FETCH_ALIGN_CHK_EN.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                WORD_SIZE = FQ_WORD_SIZE,
  parameter int                ADDR_W    = FQ_ADDR_W,
  parameter int                DEPTH     = FQ_DEPTH,
  parameter int                PC_STEP   = FQ_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FQ_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic [WORD_SIZE-1:0] ir_data,
  output logic [ADDR_W-1:0]    ir_pc
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic                 fetch_err
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fq_state_e             state_r, state_next_s;
  logic [ADDR_W-1:0]     fetch_pc_r;
  logic [CNT_W-1:0]      discard_r, discard_next_s;
  logic                  fetch_en_r;
  logic                  mem_req_s, issue_s, credit_s, halt_s, misalign_s;
  logic                  q_push_s, q_pop_s, q_full_s, q_empty_s;
  logic                  tag_full_s, tag_empty_s;
  logic [CNT_W-1:0]      q_count_s, tag_count_s;
  logic [ADDR_W-1:0]     tag_pc_s;
  logic [ADDR_W+WORD_SIZE-1:0] q_head_s;

`ifdef FETCH_ALIGN_CHK_EN
  logic fetch_err_r;
  assign misalign_s = redirect && ((redirect_pc % ADDR_W'(PC_STEP)) != '0);
  assign halt_s     = fetch_err_r;
  assign fetch_err  = fetch_err_r;

  // sticky alignment error; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_r <= 1'b0;
    end else if (misalign_s) begin
      fetch_err_r <= 1'b1;
    end
  end
`else
  assign misalign_s = 1'b0;
  assign halt_s     = 1'b0;
`endif

  // tag count doubles as the outstanding-read counter
  assign credit_s = ({1'b0, q_count_s} + {1'b0, tag_count_s}) < (CNT_W+1)'(DEPTH);
  assign issue_s  = mem_req_s && mem_gnt;
  assign q_push_s = mem_rvalid && !redirect && (discard_r == '0);
  assign q_pop_s  = !q_empty_s && ir_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FQ_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and discard count; a redirect drops every read still in flight
  always_comb begin
    discard_next_s = discard_r;
    state_next_s   = state_r;
    if (redirect) begin
      discard_next_s = tag_count_s - CNT_W'(mem_rvalid);
      state_next_s   = (misalign_s || (discard_next_s != '0)) ? FQ_FLUSH : FQ_FETCH;
    end else if (mem_rvalid && (discard_r != '0)) begin
      discard_next_s = discard_r - CNT_W'(1);
      state_next_s   = (discard_next_s == '0) ? FQ_FETCH : state_r;
    end else if ((state_r == FQ_FLUSH) && (discard_r == '0)) begin
      state_next_s   = FQ_FETCH;
    end else begin
      state_next_s   = state_r;
    end
  end

  // FSM output: request only in FETCH with a free credit and no redirect pending
  always_comb begin
    mem_req_s = 1'b0;
    if (fetch_en_r && (state_r == FQ_FETCH) && !redirect && credit_s && !halt_s) begin
      mem_req_s = 1'b1;
    end else begin
      mem_req_s = 1'b0;
    end
  end

  // fetch address, discard counter and post-reset enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      discard_r  <= '0;
      fetch_en_r <= 1'b0;
    end else begin
      fetch_en_r <= 1'b1;
      discard_r  <= discard_next_s;
      if (redirect && !misalign_s) begin
        fetch_pc_r <= redirect_pc;
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + ADDR_W'(PC_STEP);
      end
    end
  end

  fq_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .push(issue_s), .pop(mem_rvalid), .wdata(fetch_pc_r), .rdata(tag_pc_s),
    .full(tag_full_s), .empty(tag_empty_s), .count(tag_count_s)
  );

  fq_sync_fifo #(.WIDTH(ADDR_W+WORD_SIZE), .DEPTH(DEPTH)) u_data_fifo (
    .clk(clk), .rst_n(rst_n), .clr(redirect),
    .push(q_push_s), .pop(q_pop_s), .wdata({tag_pc_s, mem_rdata}), .rdata(q_head_s),
    .full(q_full_s), .empty(q_empty_s), .count(q_count_s)
  );

  fetch_queue_unit_chk u_chk (
    .clk(clk), .rst_n(rst_n), .mem_rvalid(mem_rvalid), .tag_empty(tag_empty_s),
    .tag_push(issue_s), .tag_full(tag_full_s), .q_push(q_push_s), .q_full(q_full_s)
  );

  assign mem_req  = mem_req_s;
  assign mem_addr = fetch_pc_r;
  assign ir_valid = !q_empty_s;
  assign ir_pc    = q_head_s[ADDR_W+WORD_SIZE-1:WORD_SIZE];
  assign ir_data  = q_head_s[WORD_SIZE-1:0];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a memory responder returns addr^0x12345678
// one cycle after each grant, and a monitor checks every popped head against expectations.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req, mem_gnt, mem_rvalid, redirect, ir_valid, ir_ready;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, ir_data, ir_pc;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_err;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          issue_cnt = 0;
  int          pop_cnt = 0;
  int          budget = 0;
  bit          hold = 1'b0;
  logic [63:0] exp_q [$];
  logic [31:0] pend_q [$];
  int          pop_cyc [$];
  logic [63:0] exp_e;
  logic [31:0] resp_a;

  always #5 clk = ~clk;

  fetch_queue_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data), .ir_pc(ir_pc)
`ifdef FETCH_ALIGN_CHK_EN
    , .fetch_err(fetch_err)
`endif
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // monitor: record issues for the responder, compare pops against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_gnt) begin
        pend_q.push_back(mem_addr);
        issue_cnt = issue_cnt + 1;
        budget = budget - 1;
      end
      if (ir_valid && ir_ready) begin
        pop_cnt = pop_cnt + 1;
        pop_cyc.push_back(cyc);
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL pop_unexpected got pc=%h data=%h want none", ir_pc, ir_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ir_pc, ir_data} !== exp_e) begin
            bad = bad + 1;
            $display("FAIL pop_data got pc=%h data=%h want pc=%h data=%h",
                     ir_pc, ir_data, exp_e[63:32], exp_e[31:0]);
          end
        end
      end
    end
  end

  // memory responder: grant while budget lasts, answer one cycle after each grant
  always @(posedge clk) begin
    #3;
    mem_gnt = (budget > 0);
    if (!hold && (pend_q.size() > 0)) begin
      resp_a     = pend_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mdata(resp_a);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mdata(pc)});
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while ((exp_q.size() != 0) && (n < lim)) begin
      tick();
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    chk("redirect_cycle_req", 64'(mem_req), 64'd0);
    tick();
    redirect = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0;
    int p0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; ir_ready = 1'b0;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_mem_req",  64'(mem_req),  64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_ir_valid", 64'(ir_valid), 64'd0);
    chk("rst_ir_data",  64'(ir_data),  64'd0);
    chk("rst_ir_pc",    64'(ir_pc),    64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: streaming at one instruction per cycle
    ir_ready = 1'b1;
    budget = 8;
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
    drain("t1_drain", 40);
    chk("t1_issues", 64'(issue_cnt), 64'd8);
    if (pop_cyc.size() == 8) chk("t1_back_to_back", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);
    else chk("t1_pop_count", 64'(pop_cyc.size()), 64'd8);
    chk("t1_next_addr", 64'(mem_addr), 64'h20);

    // 2: decode stalled, queue fills to DEPTH and requests stop
    i0 = issue_cnt;
    ir_ready = 1'b0;
    budget = 100;
    repeat (20) tick();
    chk("t2_issues", 64'(issue_cnt - i0), 64'd4);
    chk("t2_req_low", 64'(mem_req), 64'd0);
    chk("t2_head_pc", 64'(ir_pc), 64'h20);
    budget = 0;
    for (int k = 0; k < 4; k++) push_exp(32'h20 + 32'(4 * k));
    tick();
    ir_ready = 1'b1;
    drain("t2_drain", 20);
    tick();
    chk("t2_empty", 64'(ir_valid), 64'd0);

    // 3: redirect with three reads in flight
    i0 = issue_cnt;
    hold = 1'b1;
    budget = 3;
    for (int n = 0; (n < 20) && (issue_cnt - i0 < 3); n++) tick();
    chk("t3_in_flight", 64'(issue_cnt - i0), 64'd3);
    do_redirect(32'h100);
    hold = 1'b0;
    budget = 4;
    chk("t3_flush_req", 64'(mem_req), 64'd0);
    tick(); tick();
    chk("t3_flush_req_late", 64'(mem_req), 64'd0);
    for (int k = 0; k < 4; k++) push_exp(32'h100 + 32'(4 * k));
    drain("t3_drain", 30);
    chk("t3_issues", 64'(issue_cnt - i0), 64'd7);

    // 4: grant withheld keeps the address stable, then wrap at the top of memory
    i0 = issue_cnt;
    repeat (5) begin
      tick();
      chk("t4_addr_stable", 64'(mem_addr), 64'h110);
    end
    chk("t4_no_dup", 64'(issue_cnt - i0), 64'd0);
    budget = 1;
    push_exp(32'h110);
    drain("t4_drain", 20);
    chk("t4_one_issue", 64'(issue_cnt - i0), 64'd1);
    do_redirect(32'hFFFF_FFF8);
    budget = 3;
    push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    drain("t4_wrap_drain", 30);
    chk("t4_wrap_addr", 64'(mem_addr), 64'h4);

    // 5: pop coinciding with redirect, redirect on empty queue, back-to-back redirects
    ir_ready = 1'b0;
    budget = 2;
    repeat (6) tick();
    chk("t5_head_pc", 64'(ir_pc), 64'h4);
    p0 = pop_cnt;
    push_exp(32'h4);
    ir_ready = 1'b1;
    do_redirect(32'h200);
    ir_ready = 1'b0;
    chk("t5_single_pop", 64'(pop_cnt - p0), 64'd1);
    chk("t5_cleared", 64'(ir_valid), 64'd0);
    do_redirect(32'h300);
    chk("t5_empty_redirect_valid", 64'(ir_valid), 64'd0);
    chk("t5_empty_redirect_addr", 64'(mem_addr), 64'h300);
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    chk("t5_last_wins", 64'(mem_addr), 64'h500);
    ir_ready = 1'b1;
    budget = 1;
    push_exp(32'h500);
    drain("t5_drain", 20);

`ifdef FETCH_ALIGN_CHK_EN
    // 6: misaligned redirect halts fetching
    do_redirect(32'h102);
    i0 = issue_cnt;
    budget = 5;
    repeat (6) tick();
    chk("t6_fetch_err", 64'(fetch_err), 64'd1);
    chk("t6_req_low", 64'(mem_req), 64'd0);
    chk("t6_no_issue", 64'(issue_cnt - i0), 64'd0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
